// File: rtl/upp_frame_checker.sv
// upp_frame_checker: receive-side checker for the 16-bit uPP stream.
// Splits the stream into frames (one contiguous iENA=1 run), checks every
// word against the constant or incrementing OCS pattern, checks the frame
// length and keeps saturating counters plus last-frame status.
// Stream handshake: iENA is a pure valid qualifier with no backpressure;
// every cycle with iENA=1 carries exactly one word that must be consumed.
// Optional macro UPP_CHK_FIRST_ERR_CAPTURE_EN adds a first-error capture
// (oFE_VALID / oFE_INDEX / oFE_DATA = {expected, received}).
// oSTATE exposes the FSM state: 0=SYNC 1=IDLE 2=RUN 3=REPORT.
module upp_frame_checker #(
   parameter logic [15:0] FRAME_WORDS = 16'd64,
   parameter logic [15:0] CONST_HI    = 16'h89AB,
   parameter logic [15:0] CONST_LO    = 16'hCDEF
) (
   input  logic        iclk,
   input  logic        ireset_n,
   input  logic [15:0] iDATA_UPP,
   input  logic        iENA,
   input  logic        iMODE,
   input  logic        iCLEAR,
   output logic        oFRAME_DONE,
   output logic        oFRAME_OK,
   output logic        oLEN_ERR,
   output logic [15:0] oFRAME_CNT,
   output logic [15:0] oERR_FRAME_CNT,
   output logic [15:0] oWORD_ERR_CNT,
`ifdef UPP_CHK_FIRST_ERR_CAPTURE_EN
   output logic        oFE_VALID,
   output logic [15:0] oFE_INDEX,
   output logic [31:0] oFE_DATA,
`endif
   output logic [1:0]  oSTATE
);

   localparam logic [1:0] ST_SYNC   = 2'd0;
   localparam logic [1:0] ST_IDLE   = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_REPORT = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic        mode_q, mode_d;
   logic [15:0] prev_q, prev_d;
   logic        frame_err_q, frame_err_d;
   logic        done_q, done_d;
   logic        ok_q, ok_d;
   logic        len_err_q, len_err_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] err_frame_cnt_q, err_frame_cnt_d;
   logic [15:0] word_err_cnt_q, word_err_cnt_d;

   logic        word_start, word_run, word_chk, frame_end;
   logic        cur_mode, word_bad, len_bad, frame_bad;
   logic [15:0] cur_idx, exp_word;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Classify the current cycle and compute the expected word.
   // A word in REPORT starts a new frame just like a word in IDLE.
   always_comb begin
      word_start = iENA && ((state_q == ST_IDLE) || (state_q == ST_REPORT));
      word_run   = iENA && (state_q == ST_RUN);
      word_chk   = word_start || word_run;
      frame_end  = !iENA && (state_q == ST_RUN);
      cur_mode   = word_start ? iMODE : mode_q;
      cur_idx    = word_start ? 16'd0 : word_cnt_q;
      if (cur_mode) begin
         // Expected value follows the received previous word, so one bad
         // word produces at most two mismatches.
         exp_word = prev_q + 16'd1;
         word_bad = word_chk && (cur_idx != 16'd0) && (iDATA_UPP != exp_word);
      end else begin
         exp_word = cur_idx[0] ? CONST_LO : CONST_HI;
         word_bad = word_chk && (iDATA_UPP != exp_word);
      end
      len_bad   = (word_cnt_q != FRAME_WORDS);
      frame_bad = frame_err_q || len_bad;
   end

   // Next-state for FSM, frame tracking, status and counters; clear wins.
   always_comb begin
      state_d         = state_q;
      word_cnt_d      = word_cnt_q;
      mode_d          = mode_q;
      prev_d          = prev_q;
      frame_err_d     = frame_err_q;
      done_d          = frame_end;
      ok_d            = ok_q;
      len_err_d       = len_err_q;
      frame_cnt_d     = frame_cnt_q;
      err_frame_cnt_d = err_frame_cnt_q;
      word_err_cnt_d  = word_err_cnt_q;

      case (state_q)
         ST_SYNC:   if (!iENA) state_d = ST_IDLE;
         ST_IDLE:   if (iENA)  state_d = ST_RUN;
         ST_RUN:    if (!iENA) state_d = ST_REPORT;
         default:   state_d = iENA ? ST_RUN : ST_IDLE;
      endcase

      if (word_start) begin
         word_cnt_d  = 16'd1;
         mode_d      = iMODE;
         frame_err_d = word_bad;
      end
      if (word_run) begin
         word_cnt_d  = sat_inc(word_cnt_q);
         frame_err_d = frame_err_q || word_bad;
      end
      if (word_chk) prev_d = iDATA_UPP;
      if (word_bad) word_err_cnt_d = sat_inc(word_err_cnt_q);

      if (frame_end) begin
         len_err_d   = len_bad;
         ok_d        = !frame_bad;
         frame_cnt_d = sat_inc(frame_cnt_q);
         if (frame_bad) err_frame_cnt_d = sat_inc(err_frame_cnt_q);
      end

      if (iCLEAR) begin
         state_d         = ST_SYNC;
         word_cnt_d      = 16'd0;
         frame_err_d     = 1'b0;
         ok_d            = 1'b0;
         len_err_d       = 1'b0;
         frame_cnt_d     = 16'd0;
         err_frame_cnt_d = 16'd0;
         word_err_cnt_d  = 16'd0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge iclk) begin
      if (!ireset_n) begin
         state_q         <= ST_SYNC;
         word_cnt_q      <= 16'd0;
         mode_q          <= 1'b0;
         prev_q          <= 16'd0;
         frame_err_q     <= 1'b0;
         done_q          <= 1'b0;
         ok_q            <= 1'b0;
         len_err_q       <= 1'b0;
         frame_cnt_q     <= 16'd0;
         err_frame_cnt_q <= 16'd0;
         word_err_cnt_q  <= 16'd0;
      end else begin
         state_q         <= state_d;
         word_cnt_q      <= word_cnt_d;
         mode_q          <= mode_d;
         prev_q          <= prev_d;
         frame_err_q     <= frame_err_d;
         done_q          <= done_d;
         ok_q            <= ok_d;
         len_err_q       <= len_err_d;
         frame_cnt_q     <= frame_cnt_d;
         err_frame_cnt_q <= err_frame_cnt_d;
         word_err_cnt_q  <= word_err_cnt_d;
      end
   end

`ifdef UPP_CHK_FIRST_ERR_CAPTURE_EN
   logic        fe_valid_q;
   logic [15:0] fe_index_q;
   logic [31:0] fe_data_q;

   // Capture the first mismatch since reset/clear; later ones are ignored.
   always_ff @(posedge iclk) begin
      if (!ireset_n || iCLEAR) begin
         fe_valid_q <= 1'b0;
         fe_index_q <= 16'd0;
         fe_data_q  <= 32'd0;
      end else if (word_bad && !fe_valid_q) begin
         fe_valid_q <= 1'b1;
         fe_index_q <= cur_idx;
         fe_data_q  <= {exp_word, iDATA_UPP};
      end
   end

   assign oFE_VALID = fe_valid_q;
   assign oFE_INDEX = fe_index_q;
   assign oFE_DATA  = fe_data_q;
`endif

   assign oFRAME_DONE    = done_q;
   assign oFRAME_OK      = ok_q;
   assign oLEN_ERR       = len_err_q;
   assign oFRAME_CNT     = frame_cnt_q;
   assign oERR_FRAME_CNT = err_frame_cnt_q;
   assign oWORD_ERR_CNT  = word_err_cnt_q;
   assign oSTATE         = state_q;

endmodule

// File: tb/tb_upp_frame_checker.sv
// Directed self-checking bench for upp_frame_checker (default parameters).
module tb_upp_frame_checker;

  localparam logic [1:0] S_SYNC   = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd3;

  // clock / reset
  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic        ireset_n = 1'b0;
  logic [15:0] iDATA_UPP = 16'd0;
  logic        iENA = 1'b0;
  logic        iMODE = 1'b0;
  logic        iCLEAR = 1'b0;
  logic        oFRAME_DONE, oFRAME_OK, oLEN_ERR;
  logic [15:0] oFRAME_CNT, oERR_FRAME_CNT, oWORD_ERR_CNT;
  logic [1:0]  oSTATE;
`ifdef UPP_CHK_FIRST_ERR_CAPTURE_EN
  logic        oFE_VALID;
  logic [15:0] oFE_INDEX;
  logic [31:0] oFE_DATA;
`endif

  upp_frame_checker dut (
    .iclk           (iclk),
    .ireset_n       (ireset_n),
    .iDATA_UPP      (iDATA_UPP),
    .iENA           (iENA),
    .iMODE          (iMODE),
    .iCLEAR         (iCLEAR),
    .oFRAME_DONE    (oFRAME_DONE),
    .oFRAME_OK      (oFRAME_OK),
    .oLEN_ERR       (oLEN_ERR),
    .oFRAME_CNT     (oFRAME_CNT),
    .oERR_FRAME_CNT (oERR_FRAME_CNT),
    .oWORD_ERR_CNT  (oWORD_ERR_CNT),
`ifdef UPP_CHK_FIRST_ERR_CAPTURE_EN
    .oFE_VALID      (oFE_VALID),
    .oFE_INDEX      (oFE_INDEX),
    .oFE_DATA       (oFE_DATA),
`endif
    .oSTATE         (oSTATE)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge,
  // outputs are sampled at the same point
  task automatic tick;
    @(posedge iclk);
    #1;
  endtask

  // kind 0: correct constant pattern, 1: seed+i, 2: all zero.
  // bad_idx word gets bit 10 flipped. iMODE flips after word 0.
  task automatic send_frame(input int n, input logic mode, input int kind,
                            input logic [15:0] seed, input int bad_idx);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      if (kind == 0) w = i[0] ? 16'hCDEF : 16'h89AB;
      else if (kind == 1) w = seed + 16'(i);
      else w = 16'h0000;
      if (i == bad_idx) w = w ^ 16'h0400;
      iENA = 1'b1;
      iDATA_UPP = w;
      iMODE = (i == 0) ? mode : ~mode;
      tick;
    end
  endtask

  // last word already clocked: done must be low now and high one edge later
  task automatic end_frame(input string tag);
    check({tag, "_done_early"}, 48'(oFRAME_DONE), 48'd0);
    iENA = 1'b0;
    iDATA_UPP = 16'h0000;
    tick;
    check({tag, "_done"}, 48'(oFRAME_DONE), 48'd1);
  endtask

  task automatic idle_tick(input string tag);
    iENA = 1'b0;
    tick;
    check({tag, "_done_drop"}, 48'(oFRAME_DONE), 48'd0);
  endtask

  task automatic check_status(input string tag, input logic ok, input logic len,
                              input logic [15:0] fc, input logic [15:0] efc,
                              input logic [15:0] wec);
    check({tag, "_ok"},      48'(oFRAME_OK),      48'(ok));
    check({tag, "_len"},     48'(oLEN_ERR),       48'(len));
    check({tag, "_fcnt"},    48'(oFRAME_CNT),     48'(fc));
    check({tag, "_efcnt"},   48'(oERR_FRAME_CNT), 48'(efc));
    check({tag, "_wecnt"},   48'(oWORD_ERR_CNT),  48'(wec));
  endtask

  initial begin
    // reset state
    tick; tick;
    check_status("rst", 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    check("rst_done", 48'(oFRAME_DONE), 48'd0);
    check("rst_state", 48'(oSTATE), 48'(S_SYNC));
`ifdef UPP_CHK_FIRST_ERR_CAPTURE_EN
    check("rst_fe_valid", 48'(oFE_VALID), 48'd0);
`endif
    ireset_n = 1'b1;
    tick;
    check("sync_to_idle", 48'(oSTATE), 48'(S_IDLE));

    // constant mode, 64 good words
    send_frame(64, 1'b0, 0, 16'h0, -1);
    end_frame("const");
    check("const_state", 48'(oSTATE), 48'(S_REPORT));
    check_status("const", 1'b1, 1'b0, 16'd1, 16'd0, 16'd0);
    idle_tick("const");

    // incrementing mode across FFFF -> 0000
    send_frame(64, 1'b1, 1, 16'hFFF0, -1);
    end_frame("incwrap");
    check_status("incwrap", 1'b1, 1'b0, 16'd2, 16'd0, 16'd0);
    idle_tick("incwrap");

    // incrementing mode, word 10 corrupted: 100A -> 140A, two mismatches
    send_frame(64, 1'b1, 1, 16'h1000, 10);
    end_frame("inccorr");
    check_status("inccorr", 1'b0, 1'b0, 16'd3, 16'd1, 16'd2);
`ifdef UPP_CHK_FIRST_ERR_CAPTURE_EN
    check("inccorr_fe_valid", 48'(oFE_VALID), 48'd1);
    check("inccorr_fe_index", 48'(oFE_INDEX), 48'd10);
    check("inccorr_fe_data",  48'(oFE_DATA),  48'h100A_140A);
`endif
    idle_tick("inccorr");

    // short and long frames
    send_frame(63, 1'b0, 0, 16'h0, -1);
    end_frame("len63");
    check_status("len63", 1'b0, 1'b1, 16'd4, 16'd2, 16'd2);
    idle_tick("len63");
    send_frame(65, 1'b0, 0, 16'h0, -1);
    end_frame("len65");
    check_status("len65", 1'b0, 1'b1, 16'd5, 16'd3, 16'd2);
    idle_tick("len65");
    send_frame(64, 1'b0, 0, 16'h0, -1);
    end_frame("len64");
    check_status("len64", 1'b1, 1'b0, 16'd6, 16'd3, 16'd2);
    idle_tick("len64");

    // back-to-back: frame B starts in A's REPORT cycle
    send_frame(64, 1'b1, 1, 16'h2000, -1);
    end_frame("b2b_a");
    check_status("b2b_a", 1'b1, 1'b0, 16'd7, 16'd3, 16'd2);
    send_frame(64, 1'b0, 0, 16'h0, -1);
    end_frame("b2b_b");
    check_status("b2b_b", 1'b1, 1'b0, 16'd8, 16'd3, 16'd2);
    idle_tick("b2b_b");

    // reset taken and released in the middle of a frame
    iENA = 1'b1;
    iDATA_UPP = 16'h89AB;
    ireset_n = 1'b0;
    tick; tick;
    check_status("midrst", 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    ireset_n = 1'b1;
    send_frame(20, 1'b0, 0, 16'h0, -1);
    check("midrst_state", 48'(oSTATE), 48'(S_SYNC));
    iENA = 1'b0;
    tick;
    check("midrst_nodone", 48'(oFRAME_DONE), 48'd0);
    check("midrst_fcnt", 48'(oFRAME_CNT), 48'd0);
    check("midrst_idle", 48'(oSTATE), 48'(S_IDLE));
    send_frame(64, 1'b0, 0, 16'h0, -1);
    end_frame("postrst");
    check_status("postrst", 1'b1, 1'b0, 16'd1, 16'd0, 16'd0);
    idle_tick("postrst");

    // clear coinciding with frame end: done pulses, status forced to 0
    send_frame(64, 1'b0, 0, 16'h0, -1);
    iCLEAR = 1'b1;
    end_frame("clrrep");
    iCLEAR = 1'b0;
    check_status("clrrep", 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    check("clrrep_state", 48'(oSTATE), 48'(S_SYNC));
    idle_tick("clrrep");
    check("clrrep_idle", 48'(oSTATE), 48'(S_IDLE));

    // word error counter saturation: 65534 bad words then 3 more
    send_frame(65534, 1'b0, 2, 16'h0, -1);
    end_frame("sat1");
    check_status("sat1", 1'b0, 1'b1, 16'd1, 16'd1, 16'hFFFE);
    idle_tick("sat1");
    send_frame(3, 1'b0, 2, 16'h0, -1);
    end_frame("sat2");
    check_status("sat2", 1'b0, 1'b1, 16'd2, 16'd2, 16'hFFFF);
`ifdef UPP_CHK_FIRST_ERR_CAPTURE_EN
    check("sat_fe_index", 48'(oFE_INDEX), 48'd0);
    check("sat_fe_data",  48'(oFE_DATA),  48'h89AB_0000);
`endif
    idle_tick("sat2");

    // plain clear
    iCLEAR = 1'b1;
    tick;
    iCLEAR = 1'b0;
    check_status("clr", 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    check("clr_state", 48'(oSTATE), 48'(S_SYNC));
`ifdef UPP_CHK_FIRST_ERR_CAPTURE_EN
    check("clr_fe_valid", 48'(oFE_VALID), 48'd0);
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
